// File: rtl/seq_piso_serializer.sv
// seq_piso_serializer
// Parallel-in / serial-out feeder for a 0110 sequence detector. Words arrive
// through a valid/ready handshake into a one-word holding buffer and are
// shifted out MSB first, one bit per clock. The holding buffer lets the next
// word be reloaded on the same edge that the last bit of the current word
// retires, so a well-fed stream has no idle bits between words. When nothing
// is shifting, dout rests at IDLE_BIT.
//
// Handshake: a transfer happens on a rising edge where data_valid and
// data_ready are both high; data_in is sampled only on that edge. data_ready
// is simply "holding buffer empty" (and low while reset is asserted). The
// producer may change or withdraw data_valid/data_in freely between transfers.

module seq_piso_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             dout,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             dbg_state
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] hbuf;
    logic             hvalid;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] cnt;

    // Control strobes produced by the FSM for the datapath registers.
    logic             accept;
    logic             load;
    logic             shift;

    // Buffer can take a word whenever it is empty; held low during reset.
    always_comb begin
        data_ready = reset && !hvalid;
        accept     = data_valid && data_ready;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: decide whether to load the buffered word, shift, or go idle.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hvalid) begin
                    load       = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt != CNT_LAST) begin
                    shift = 1'b1;
                end else if (hvalid) begin
                    // Last bit of this word: chain straight into the next one.
                    load = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Holding buffer. Accept and load never coincide: a load needs hvalid=1,
    // which keeps data_ready low on that same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hbuf   <= '0;
            hvalid <= 1'b0;
        end else if (accept) begin
            hbuf   <= data_in;
            hvalid <= 1'b1;
        end else if (load) begin
            hvalid <= 1'b0;
        end
    end

    // Shift register and bit counter for the word on the wire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= hbuf;
            cnt  <= '0;
        end else if (shift) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
            cnt  <= cnt + CNT_W'(1);
        end
    end

    // Serial outputs depend on registered state only.
    always_comb begin
        dout        = IDLE_BIT;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        if (state == ST_SHIFT) begin
            dout        = sreg[WIDTH-1];
            bit_valid   = 1'b1;
            frame_start = (cnt == '0);
        end
        busy      = (state == ST_SHIFT) || hvalid;
        dbg_state = state;
    end

endmodule
